// File: rtl/operand_loader_pkg.sv
// Shared parameters and types for the operand loader: SRAM geometry and the
// loader FSM state encoding.
package operand_loader_pkg;

  localparam int ADDR_W        = 9;
  localparam int MEM_WORD_SIZE = 64;
  localparam int LOAD_CNT_W    = ADDR_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    LAST = 2'd2,
    DONE = 2'd3
  } loader_state_e;

endpackage

// File: rtl/operand_loader_if.sv
// Operand stream (valid/ready) plus the SRAM port-0 write bus driven by the loader.
interface operand_loader_if;
  import operand_loader_pkg::*;

  logic                     in_valid_i;
  logic [MEM_WORD_SIZE-1:0] in_data_i;
  logic                     in_ready_o;
  logic                     write_o;
  logic [ADDR_W-1:0]        w_addr_o;
  logic [MEM_WORD_SIZE-1:0] w_data_o;

  modport slave (
    input  in_valid_i, in_data_i,
    output in_ready_o, write_o, w_addr_o, w_data_o
  );

  modport master (
    output in_valid_i, in_data_i,
    input  in_ready_o, write_o, w_addr_o, w_data_o
  );

endinterface

// File: rtl/operand_loader.sv
// Streams 64-bit operand words into SRAM port 0 over an inclusive address range,
// pulsing done_o one cycle after the final write is presented.
module operand_loader
  import operand_loader_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [ADDR_W-1:0]     load_start_addr,
  input  logic [ADDR_W-1:0]     load_end_addr,
  operand_loader_if.slave       ld,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [LOAD_CNT_W-1:0] word_count_o
);

  loader_state_e            state_q, state_d;
  logic [ADDR_W-1:0]        cur_addr_q, cur_addr_d;
  logic [ADDR_W-1:0]        end_addr_q, end_addr_d;
  logic [ADDR_W-1:0]        w_addr_q, w_addr_d;
  logic [MEM_WORD_SIZE-1:0] w_data_q, w_data_d;
  logic                     write_q, write_d;
  logic                     err_q, err_d;
  logic [LOAD_CNT_W-1:0]    cnt_q, cnt_d;

  // State, address counter and registered write port.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cur_addr_q <= '0;
      end_addr_q <= '0;
      w_addr_q   <= '0;
      w_data_q   <= '0;
      write_q    <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      end_addr_q <= end_addr_d;
      w_addr_q   <= w_addr_d;
      w_data_q   <= w_data_d;
      write_q    <= write_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  // Next-state logic; w_addr/w_data hold their value on cycles without a write.
  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    end_addr_d = end_addr_q;
    w_addr_d   = w_addr_q;
    w_data_d   = w_data_q;
    write_d    = 1'b0;
    err_d      = err_q;
    cnt_d      = cnt_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (load_start_addr <= load_end_addr) begin
            state_d    = LOAD;
            cur_addr_d = load_start_addr;
            end_addr_d = load_end_addr;
            cnt_d      = '0;
            err_d      = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        if (ld.in_valid_i) begin
          write_d    = 1'b1;
          w_addr_d   = cur_addr_q;
          w_data_d   = ld.in_data_i;
          cur_addr_d = cur_addr_q + ADDR_W'(1);
          cnt_d      = cnt_q + LOAD_CNT_W'(1);
          // Compare before increment so a range ending at 511 never wraps into a match.
          if (cur_addr_q == end_addr_q) begin
            state_d = LAST;
          end else begin
            state_d = LOAD;
          end
        end else begin
          state_d = LOAD;
        end
      end
      LAST:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status outputs decoded from the state register.
  always_comb begin
    ld.in_ready_o = 1'b0;
    busy_o        = 1'b0;
    done_o        = 1'b0;
    case (state_q)
      IDLE: begin
        busy_o = 1'b0;
      end
      LOAD: begin
        ld.in_ready_o = 1'b1;
        busy_o        = 1'b1;
      end
      LAST: begin
        busy_o = 1'b1;
      end
      DONE: begin
        busy_o = 1'b1;
        done_o = 1'b1;
      end
      default: begin
        busy_o = 1'b0;
      end
    endcase
  end

  assign ld.write_o    = write_q;
  assign ld.w_addr_o   = w_addr_q;
  assign ld.w_data_o   = w_data_q;
  assign err_o         = err_q;
  assign word_count_o  = cnt_q;

endmodule

// File: tb/tb_operand_loader.sv
// Bench for operand_loader: vector table of load ranges, scoreboard of expected
// SRAM writes, a behavioural SRAM for readback, and a reset-mid-load sequence.
module tb_operand_loader;
  import operand_loader_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  start;
  logic [ADDR_W-1:0]     sa, ea;
  logic                  busy, done, err;
  logic [LOAD_CNT_W-1:0] wcnt;

  operand_loader_if ifc ();

  operand_loader dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .start_i         (start),
    .load_start_addr (sa),
    .load_end_addr   (ea),
    .ld              (ifc),
    .busy_o          (busy),
    .done_o          (done),
    .err_o           (err),
    .word_count_o    (wcnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [63:0]       data;
  } wr_t;

  typedef struct {
    logic [ADDR_W-1:0] sa;
    logic [ADDR_W-1:0] ea;
    logic [7:0]        vpat;
    logic [63:0]       dbase;
    bit                exp_err;
    int                exp_cnt;
  } vec_t;

  wr_t         exp_q[$];
  wr_t         mon_e;
  vec_t        vecs[5];
  int          errors   = 0;
  int          checks   = 0;
  int          done_cnt = 0;
  bit          mon_en   = 1'b0;
  logic [31:0] mem_a[512];
  logic [31:0] mem_b[512];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural SRAM: captures the write presented during the cycle ending at this edge.
  always @(posedge clk) begin
    if (ifc.write_o === 1'b1) begin
      mem_a[ifc.w_addr_o] <= ifc.w_data_o[31:0];
      mem_b[ifc.w_addr_o] <= ifc.w_data_o[63:32];
    end
  end

  // Write monitor: every write strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (mon_en && ifc.write_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr %0h data %0h, expected no write", ifc.w_addr_o, ifc.w_data_o);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", 64'(ifc.w_addr_o), 64'(mon_e.addr));
        chk("wr_data", ifc.w_data_o, mon_e.data);
      end
    end
    if (mon_en && done === 1'b1) done_cnt++;
  end

  task automatic run_vec(input vec_t v);
    int                n   = 0;
    int                cyc = 0;
    int                d0  = done_cnt;
    logic              vb;
    logic [ADDR_W-1:0] a   = v.sa;
    @(negedge clk);
    start = 1'b1; sa = v.sa; ea = v.ea;
    @(negedge clk);
    start = 1'b0;
    if (v.exp_err) begin
      chk("err_set",   64'(err), 64'd1);
      chk("err_busy",  64'(busy), 64'd0);
      chk("err_ready", 64'(ifc.in_ready_o), 64'd0);
      // Offer a word while idle; it must not be accepted.
      ifc.in_valid_i = 1'b1;
      ifc.in_data_i  = 64'hBAD0_BAD0_BAD0_BAD0;
      repeat (4) @(negedge clk);
      ifc.in_valid_i = 1'b0;
      chk("err_sticky",  64'(err), 64'd1);
      chk("err_no_done", 64'(done_cnt), 64'(d0));
      chk("err_no_busy", 64'(busy), 64'd0);
    end else begin
      chk("start_ready",   64'(ifc.in_ready_o), 64'd1);
      chk("start_busy",    64'(busy), 64'd1);
      chk("start_err_clr", 64'(err), 64'd0);
      chk("start_cnt_clr", 64'(wcnt), 64'd0);
      while (n < v.exp_cnt && cyc < 4096) begin
        vb = v.vpat[3'(cyc)];
        ifc.in_valid_i = vb;
        ifc.in_data_i  = v.dbase + 64'(n);
        if (vb) begin
          exp_q.push_back('{a, v.dbase + 64'(n)});
          a++;
          n++;
        end
        @(negedge clk);
        chk("write_strobe", 64'(ifc.write_o), 64'(vb));
        cyc++;
      end
      chk("load_cycle_budget", 64'(n), 64'(v.exp_cnt));
      ifc.in_valid_i = 1'b0;
      chk("last_ready", 64'(ifc.in_ready_o), 64'd0);
      chk("last_busy",  64'(busy), 64'd1);
      chk("last_no_done", 64'(done), 64'd0);
      @(negedge clk);
      chk("done_pulse", 64'(done), 64'd1);
      chk("done_nowr",  64'(ifc.write_o), 64'd0);
      chk("done_busy",  64'(busy), 64'd1);
      @(negedge clk);
      chk("idle_done",  64'(done), 64'd0);
      chk("idle_busy",  64'(busy), 64'd0);
      chk("word_count", 64'(wcnt), 64'(v.exp_cnt));
      chk("done_once",  64'(done_cnt), 64'(d0 + 1));
      chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      for (int i = 0; i < v.exp_cnt; i++) begin
        chk("sram_a", 64'(mem_a[v.sa + ADDR_W'(i)]), 64'((v.dbase + 64'(i)) & 64'hFFFF_FFFF));
        chk("sram_b", 64'(mem_b[v.sa + ADDR_W'(i)]), 64'((v.dbase + 64'(i)) >> 32));
      end
    end
  endtask

  task automatic reset_midload();
    int d0 = done_cnt;
    @(negedge clk);
    start = 1'b1; sa = 9'h040; ea = 9'h047;
    @(negedge clk);
    chk("rst_seq_ready", 64'(ifc.in_ready_o), 64'd1);
    for (int i = 0; i < 3; i++) begin
      // A start pulse in LOAD with a different range must be ignored.
      if (i == 0) begin
        start = 1'b1; sa = 9'h0AA; ea = 9'h0AB;
      end else begin
        start = 1'b0;
      end
      ifc.in_valid_i = 1'b1;
      ifc.in_data_i  = 64'hA5A5_0000_0000_0000 + 64'(i);
      exp_q.push_back('{9'h040 + ADDR_W'(i), 64'hA5A5_0000_0000_0000 + 64'(i)});
      @(negedge clk);
      chk("rst_seq_write", 64'(ifc.write_o), 64'd1);
    end
    start = 1'b0;
    rst   = 1'b1;
    ifc.in_data_i = 64'hA5A5_0000_0000_0003;
    @(negedge clk);
    rst = 1'b0;
    ifc.in_valid_i = 1'b0;
    chk("rst_ready", 64'(ifc.in_ready_o), 64'd0);
    chk("rst_write", 64'(ifc.write_o), 64'd0);
    chk("rst_busy",  64'(busy), 64'd0);
    chk("rst_done",  64'(done), 64'd0);
    chk("rst_err",   64'(err), 64'd0);
    chk("rst_waddr", 64'(ifc.w_addr_o), 64'd0);
    chk("rst_wdata", ifc.w_data_o, 64'd0);
    chk("rst_count", 64'(wcnt), 64'd0);
    repeat (3) @(negedge clk);
    chk("rst_stays_idle", 64'(busy), 64'd0);
    chk("rst_no_done", 64'(done_cnt), 64'(d0));
    chk("rst_scoreboard", 64'(exp_q.size()), 64'd0);
    for (int i = 0; i < 3; i++) begin
      chk("rst_written_a", 64'(mem_a[9'h040 + ADDR_W'(i)]), 64'(i));
      chk("rst_written_b", 64'(mem_b[9'h040 + ADDR_W'(i)]), 64'hA5A5_0000);
    end
    // Untouched locations keep the full-range pattern (data == address).
    for (int i = 3; i < 8; i++) begin
      chk("rst_untouched_a", 64'(mem_a[9'h040 + ADDR_W'(i)]), 64'(32'h40 + 32'(i)));
      chk("rst_untouched_b", 64'(mem_b[9'h040 + ADDR_W'(i)]), 64'd0);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; sa = '0; ea = '0;
    ifc.in_valid_i = 1'b0;
    ifc.in_data_i  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", 64'(ifc.in_ready_o), 64'd0);
    chk("reset_write", 64'(ifc.write_o), 64'd0);
    chk("reset_busy",  64'(busy), 64'd0);
    chk("reset_done",  64'(done), 64'd0);
    chk("reset_err",   64'(err), 64'd0);
    chk("reset_waddr", 64'(ifc.w_addr_o), 64'd0);
    chk("reset_wdata", ifc.w_data_o, 64'd0);
    chk("reset_count", 64'(wcnt), 64'd0);
    rst    = 1'b0;
    mon_en = 1'b1;

    vecs[0] = '{9'h010, 9'h013, 8'hFF, 64'h1,                   1'b0, 4};
    vecs[1] = '{9'h005, 9'h005, 8'hFF, 64'hDEAD_BEEF_0000_0001, 1'b0, 1};
    vecs[2] = '{9'h020, 9'h022, 8'hE9, 64'h0123_4567_89AB_CDEF, 1'b0, 3};
    vecs[3] = '{9'h100, 9'h0FF, 8'hFF, 64'h0,                   1'b1, 0};
    vecs[4] = '{9'h000, 9'h1FF, 8'hFF, 64'h0,                   1'b0, 512};

    for (int k = 0; k < 5; k++) run_vec(vecs[k]);
    reset_midload();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/operand_loader.md
# operand_loader

Upstream stage of the calculator datapath. It accepts 64-bit operand words from an external valid/ready stream and writes them into SRAM port 0 of both memory halves over a configured inclusive address range. When the last word is written it pulses `done_o`, which releases the controller to begin its read–add–write pass. `top_lvl` muxes this block's write port with the controller's write port: the loader owns port 0 while `busy_o` is high.

## Interface
Parameters (from `calculator_pkg`, not overridden per instance):
- ADDR_W, 9: SRAM word address width (512 entries)
- MEM_WORD_SIZE, 64: stream/SRAM word width; [31:0] goes to SRAM_A, [63:32] to SRAM_B

Ports:
- clk_i  in  1  single clock shared with controller and SRAMs
- rst_i  in  1  reset, synchronous, active-high
- start_i  in  1  one-cycle pulse; sampled only in IDLE
- load_start_addr  in  ADDR_W  first address written; sampled with start_i
- load_end_addr  in  ADDR_W  last address written (inclusive); sampled with start_i
- in_valid_i  in  1  stream word valid
- in_data_i  in  MEM_WORD_SIZE  stream word
- in_ready_o  out  1  loader accepts a word this cycle
- write_o  out  1  SRAM port-0 write strobe; top drives csb0 = web0 = ~write_o
- w_addr_o  out  ADDR_W  SRAM write address
- w_data_o  out  MEM_WORD_SIZE  SRAM write data
- busy_o  out  1  high in LOAD, LAST and DONE
- done_o  out  1  one-cycle pulse after the final write
- err_o  out  1  sticky range error; cleared by the next accepted start_i
- word_count_o  out  ADDR_W+1  number of words written in the current or most recent load

## Operation
States:
- IDLE
- LOAD
- LAST
- DONE

Transitions:
- IDLE, start_i=1 with start ≤ end → LOAD. Latch cur_addr=start and end_addr=end. Clear word_count_o and err_o.
- IDLE, start_i=1 with start > end → stay in IDLE. Set err_o=1. Perform no writes, no done_o.
- LOAD: in_ready_o=1. A word is accepted on a cycle where in_valid_i & in_ready_o are both high.
- On each accepted word, register write_o=1, w_addr_o=cur_addr, w_data_o=in_data_i; then increment cur_addr and word_count_o.
- If the accepted word is at cur_addr==end_addr, go LOAD → LAST.
- LAST: in_ready_o=0. The final write is presented this cycle. Go → DONE.
- DONE: done_o=1, write_o=0. Go → IDLE.

Behaviour rules:
- Bubbles (in_valid_i=0 in LOAD) produce write_o=0 that cycle; the address does not advance.
- start_i outside IDLE is ignored. In IDLE, in_valid_i is not accepted (in_ready_o=0).
- Single-word range (start==end): accept one word, then LAST, then DONE.
- Full range 0..511: 512 writes, word_count_o=512. No address wrap: cur_addr is never compared past end_addr. An increment past 511 occurs only when entering LAST and is unused.
- Reset mid-load returns to IDLE with all outputs cleared. Words already written remain in SRAM. No done_o is produced.
- w_addr_o and w_data_o hold their last value when write_o=0.

## Timing
Reset values (next rising edge with rst_i=1):
- state=IDLE
- in_ready_o=0, write_o=0, busy_o=0, done_o=0, err_o=0
- w_addr_o=0, w_data_o=0, word_count_o=0

Latency:
- Accept at edge k → write_o/w_addr_o/w_data_o visible in cycle k+1. The SRAM captures the data at edge k+2.
- Throughput: one word per cycle.
- start_i at edge s → LOAD and in_ready_o=1 in cycle s+1.
- Last accept at edge k → LAST during cycle k+1 (final write) → DONE with done_o=1 in cycle k+2 → IDLE in cycle k+3.
- Minimum load of N words with no bubbles: done_o appears N+2 cycles after in_ready_o first rises.
- The controller must not read the final address before done_o. The SRAM write completes at the edge that starts the DONE cycle.

## Structure
- `calculator_pkg` additions: `loader_state_e` enum (IDLE, LOAD, LAST, DONE) and `LOAD_CNT_W = ADDR_W+1`. Reuse the existing ADDR_W and MEM_WORD_SIZE.
- Single module, no sub-modules. Output write registers, address counter and FSM are in one always_ff; next-state logic is in an always_comb.
- `top_lvl` change: port-0 addr/din/csb/web are muxed by busy_o between this block and the controller. The controller is held idle until done_o.

## Test plan
- Reset, then start 0x010..0x013 with 4 back-to-back words 0x1..0x4 → writes at 0x010..0x013 on consecutive cycles, done_o 2 cycles after the last accept, word_count_o=4, SRAM readback matches.
- Start 0x005..0x005, one word 0xDEADBEEF_00000001 → one write at 0x005, then LAST, then DONE. SRAM_A holds 0x00000001 and SRAM_B holds 0xDEADBEEF.
- Start 0x020..0x022 with in_valid_i toggling 1,0,0,1,0,1 → exactly 3 writes at 0x020, 0x021, 0x022; write_o is low on bubble cycles.
- Start 0x100..0x0FF → err_o=1, no write_o, no done_o, busy_o=0. The next valid start clears err_o.
- Full range 0..511 of incrementing data → 512 writes, word_count_o=512, done_o once, no write to any address after 511.
- Reset asserted after 3 of 8 words into 0x040..0x047 → next cycle IDLE with all outputs 0. 0x040..0x042 are written, 0x043+ untouched, no done_o. start_i pulsed in LOAD is ignored.
